// File: rtl/uart_sram_loader_pkg.sv
// uart_sram_loader_pkg: ACIA register selects, status bits, opcodes and state encodings
package uart_sram_loader_pkg;
   localparam logic       RS_STAT  = 1'b0;
   localparam logic       RS_DATA  = 1'b1;
   localparam int         ST_RDRF  = 0;
   localparam int         ST_TDRE  = 1;
   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   typedef enum logic [3:0] {
      INIT, POLL_RX, GET_RX, CMD, ADDR_HI, ADDR_LO, LEN, WR_MEM, RD_MEM, POLL_TX, PUT_TX
   } state_t;
   typedef enum logic [1:0] {BM_IDLE, BM_STROBE, BM_CAPTURE} bm_phase_t;
   function automatic logic [8:0] frame_len(input logic [7:0] b);
      return (b == 8'h00) ? 9'd256 : {1'b0, b};
   endfunction
endpackage

// File: rtl/uart_sram_loader_acia_bus_master.sv
// acia_bus_master: one ACIA access per request with a single-cycle strobe and a done pulse
module acia_bus_master
   import uart_sram_loader_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic       we,
   input  logic       rs,
   input  logic [7:0] wdata,
   output logic       done,
   output logic [7:0] rdata,
   output logic       acia_cs,
   output logic       acia_we,
   output logic       acia_rs,
   output logic [7:0] acia_din,
   input  logic [7:0] acia_dout
);
   bm_phase_t ph;
   // Launch on an idle request, strobe one cycle, capture read data the cycle after the strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ph       <= BM_IDLE;
         done     <= 1'b0;
         rdata    <= 8'h00;
         acia_cs  <= 1'b0;
         acia_we  <= 1'b0;
         acia_rs  <= 1'b0;
         acia_din <= 8'h00;
      end else begin
         done    <= 1'b0;
         acia_cs <= 1'b0;
         case (ph)
            BM_IDLE: if (req && !done) begin
               ph      <= BM_STROBE;
               acia_cs <= 1'b1;
               acia_we <= we;
               acia_rs <= rs;
               if (we) acia_din <= wdata;
            end
            BM_STROBE: ph <= BM_CAPTURE;
            default: begin
               ph   <= BM_IDLE;
               done <= 1'b1;
               if (!acia_we) rdata <= acia_dout;
            end
         endcase
      end
   end
endmodule

// File: rtl/uart_sram_loader.sv
// uart_sram_loader: serial command sequencer that writes/reads SRAM through an ACIA
module uart_sram_loader
   import uart_sram_loader_pkg::*;
#(
   parameter logic [7:0] INIT_CTRL = 8'h15,
   parameter logic [7:0] ACK_BYTE  = 8'h2E
)(
   input  logic        clk,
   input  logic        reset,
   output logic        acia_cs,
   output logic        acia_we,
   output logic        acia_rs,
   output logic [7:0]  acia_din,
   input  logic [7:0]  acia_dout,
   output logic        sram_oe,
   output logic        sram_we,
   output logic [15:0] addr,
   output logic [7:0]  sram_dout,
   input  logic [7:0]  sram_din,
   output logic        busy
);
   state_t     state, state_d, ret;
   logic       bm_req, bm_we, bm_rs, bm_done, op_rd;
   logic [7:0] bm_wdata, bm_rdata, rxb, txb;
   logic [8:0] cnt;
   logic [1:0] rd_wait;

   acia_bus_master u_bm (
      .clk(clk), .reset(reset), .req(bm_req), .we(bm_we), .rs(bm_rs), .wdata(bm_wdata),
      .done(bm_done), .rdata(bm_rdata), .acia_cs(acia_cs), .acia_we(acia_we),
      .acia_rs(acia_rs), .acia_din(acia_din), .acia_dout(acia_dout)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= INIT;
      else state <= state_d;
   end

   // Next state and ACIA access request for the current state
   always_comb begin
      state_d  = state;
      bm_req   = 1'b0;
      bm_we    = 1'b0;
      bm_rs    = RS_STAT;
      bm_wdata = txb;
      case (state)
         INIT: begin
            bm_req   = 1'b1;
            bm_we    = 1'b1;
            bm_wdata = INIT_CTRL;
            if (bm_done) state_d = POLL_RX;
         end
         POLL_RX: begin
            bm_req = 1'b1;
            if (bm_done && bm_rdata[ST_RDRF]) state_d = GET_RX;
         end
         GET_RX: begin
            bm_req = 1'b1;
            bm_rs  = RS_DATA;
            if (bm_done) state_d = ret;
         end
         CMD, ADDR_HI, ADDR_LO: state_d = POLL_RX;
         LEN: state_d = op_rd ? RD_MEM : POLL_RX;
         WR_MEM: state_d = (cnt == 9'd1) ? POLL_TX : POLL_RX;
         RD_MEM: state_d = (rd_wait == 2'd3) ? POLL_TX : RD_MEM;
         POLL_TX: begin
            bm_req = 1'b1;
            if (bm_done && bm_rdata[ST_TDRE]) state_d = PUT_TX;
         end
         PUT_TX: begin
            bm_req = 1'b1;
            bm_we  = 1'b1;
            bm_rs  = RS_DATA;
            if (bm_done) state_d = (op_rd && cnt != 9'd0) ? RD_MEM : POLL_RX;
         end
         default: state_d = INIT;
      endcase
   end

   // Frame field capture, SRAM strobes, address stepping and byte counting
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ret       <= CMD;
         rxb       <= 8'h00;
         txb       <= 8'h00;
         cnt       <= 9'd0;
         rd_wait   <= 2'd0;
         op_rd     <= 1'b0;
         busy      <= 1'b0;
         addr      <= 16'h0000;
         sram_dout <= 8'h00;
         sram_we   <= 1'b0;
         sram_oe   <= 1'b0;
      end else begin
         sram_we <= 1'b0;
         if (sram_we) addr <= addr + 16'd1;
         case (state)
            GET_RX: if (bm_done) rxb <= bm_rdata;
            CMD: if (rxb == OP_WRITE || rxb == OP_READ) begin
               busy  <= 1'b1;
               op_rd <= (rxb == OP_READ);
               ret   <= ADDR_HI;
            end
            ADDR_HI: begin
               addr[15:8] <= rxb;
               ret        <= ADDR_LO;
            end
            ADDR_LO: begin
               addr[7:0] <= rxb;
               ret       <= LEN;
            end
            LEN: begin
               cnt <= frame_len(rxb);
               ret <= WR_MEM;
            end
            WR_MEM: begin
               sram_dout <= rxb;
               sram_we   <= 1'b1;
               cnt       <= cnt - 9'd1;
               if (cnt == 9'd1) txb <= ACK_BYTE;
            end
            RD_MEM: begin
               rd_wait <= rd_wait + 2'd1;
               sram_oe <= (rd_wait != 2'd3);
               if (rd_wait == 2'd3) begin
                  txb  <= sram_din;
                  cnt  <= cnt - 9'd1;
                  addr <= addr + 16'd1;
               end
            end
            PUT_TX: if (bm_done && !(op_rd && cnt != 9'd0)) begin
               busy  <= 1'b0;
               op_rd <= 1'b0;
               ret   <= CMD;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_sram_loader.sv
// tb_uart_sram_loader: ACIA/SRAM models, table vectors, corner sequences and random frames
module tb_uart_sram_loader;
   typedef logic [7:0] byte_q_t [$];
   typedef struct {
      int         nrx;
      logic [7:0] rx [8];
      int         ntx;
      logic [7:0] tx [2];
      int         nwr;
      int         nchk;
      logic [15:0] ca [3];
      logic [7:0]  cv [3];
      logic        busy;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        acia_cs, acia_we, acia_rs, sram_oe, sram_we, busy;
   logic [7:0]  acia_din, sram_dout;
   logic [7:0]  acia_dout = 8'h00;
   logic [7:0]  sram_din = 8'h00;
   logic [7:0]  rd_pipe = 8'h00;
   logic [15:0] addr;

   logic [7:0]  mem [65536];
   logic [7:0]  ref_mem [65536];
   logic [7:0]  rxq [$];
   logic [7:0]  txq [$];
   logic [15:0] wr_log [$];
   int          ctrl_writes = 0, status_reads = 0, wr_count = 0, viol = 0;
   int          checks = 0, fails = 0;
   logic [7:0]  last_ctrl = 8'h00;
   logic        prev_cs = 1'b0, busy_seen = 1'b0, tdre, rdrf;
   vec_t        vt [5];

   uart_sram_loader dut (
      .clk(clk), .reset(reset), .acia_cs(acia_cs), .acia_we(acia_we), .acia_rs(acia_rs),
      .acia_din(acia_din), .acia_dout(acia_dout), .sram_oe(sram_oe), .sram_we(sram_we),
      .addr(addr), .sram_dout(sram_dout), .sram_din(sram_din), .busy(busy)
   );

   always #5 clk = ~clk;

   // ACIA and SRAM behaviour plus bus-rule monitoring
   always @(posedge clk) begin
      if (acia_cs && (sram_we || sram_oe)) viol++;
      if (sram_we && sram_oe) viol++;
      if (acia_cs && prev_cs) viol++;
      prev_cs = acia_cs;
      if (busy) busy_seen = 1'b1;
      if (acia_cs && acia_we && !acia_rs) begin
         ctrl_writes++;
         last_ctrl = acia_din;
      end
      if (acia_cs && acia_we && acia_rs) txq.push_back(acia_din);
      if (acia_cs && !acia_we && !acia_rs) begin
         status_reads++;
         tdre = ($urandom_range(0, 2) != 0);
         rdrf = (rxq.size() != 0) && ($urandom_range(0, 3) != 0);
         acia_dout <= {6'd0, tdre, rdrf};
      end
      if (acia_cs && !acia_we && acia_rs) begin
         if (rxq.size() == 0) begin
            viol++;
            acia_dout <= 8'h00;
         end else acia_dout <= rxq.pop_front();
      end
      if (sram_we) begin
         mem[addr] = sram_dout;
         wr_count++;
         wr_log.push_back(addr);
      end
      rd_pipe  <= sram_oe ? mem[addr] : 8'h00;
      sram_din <= rd_pipe;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Frame semantics: writes fill memory then ACK, reads return bytes, unknown opcodes are skipped
   task automatic model(input byte_q_t b, output byte_q_t etx, output int nwr);
      int i = 0;
      etx = {};
      nwr = 0;
      while (i < b.size()) begin
         logic [7:0]  op;
         logic [15:0] a;
         int          n;
         op = b[i];
         if (op != 8'h57 && op != 8'h52) begin
            i++;
            continue;
         end
         a = {b[i+1], b[i+2]};
         n = (b[i+3] == 8'h00) ? 256 : int'(b[i+3]);
         i += 4;
         for (int k = 0; k < n; k++) begin
            if (op == 8'h57) begin
               ref_mem[a] = b[i+k];
               nwr++;
            end else etx.push_back(ref_mem[a]);
            a = a + 16'd1;
         end
         if (op == 8'h57) begin
            etx.push_back(8'h2E);
            i += n;
         end
      end
   endtask

   task automatic run(input byte_q_t b, input int ntx);
      int t = 0;
      int lim = 60 * (b.size() + ntx) + 300;
      txq.delete();
      wr_log.delete();
      wr_count  = 0;
      busy_seen = 1'b0;
      foreach (b[i]) rxq.push_back(b[i]);
      while (!(rxq.size() == 0 && txq.size() >= ntx && !busy) && t < lim) begin
         @(posedge clk);
         t++;
      end
      repeat (30) @(posedge clk);
      @(negedge clk);
      check("done_in_time", 64'(t < lim), 64'(1));
   endtask

   task automatic run_model(input string name, input byte_q_t b);
      byte_q_t etx;
      int      nwr;
      int      bad = 0;
      model(b, etx, nwr);
      run(b, etx.size());
      check({name, "_tx_count"}, 64'(txq.size()), 64'(etx.size()));
      foreach (etx[i]) if (i >= txq.size() || txq[i] !== etx[i]) bad++;
      check({name, "_tx_bytes_bad"}, 64'(bad), 64'(0));
      check({name, "_writes"}, 64'(wr_count), 64'(nwr));
      bad = 0;
      foreach (wr_log[i]) if (mem[wr_log[i]] !== ref_mem[wr_log[i]]) bad++;
      check({name, "_mem_bad"}, 64'(bad), 64'(0));
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ctl"}, 64'({acia_cs, acia_we, acia_rs, sram_oe, sram_we, busy}), 64'(0));
      check({name, "_data"}, 64'({addr, acia_din, sram_dout}), 64'(0));
   endtask

   initial begin
      byte_q_t     b, etx;
      int          nwr, cw0, t;
      logic [7:0]  op;
      logic [15:0] a;
      vt[0] = '{nrx:7, rx:'{8'h57, 8'h12, 8'h34, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00},
                ntx:1, tx:'{8'h2E, 8'h00}, nwr:3, nchk:3,
                ca:'{16'h1234, 16'h1235, 16'h1236}, cv:'{8'hAA, 8'hBB, 8'hCC}, busy:1'b1};
      vt[1] = '{nrx:4, rx:'{8'h52, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00},
                ntx:2, tx:'{8'h11, 8'h22}, nwr:0, nchk:2,
                ca:'{16'hFFFF, 16'h0000, 16'h0000}, cv:'{8'h11, 8'h22, 8'h22}, busy:1'b1};
      vt[2] = '{nrx:1, rx:'{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                ntx:0, tx:'{8'h00, 8'h00}, nwr:0, nchk:0,
                ca:'{16'h0000, 16'h0000, 16'h0000}, cv:'{8'h00, 8'h00, 8'h00}, busy:1'b0};
      vt[3] = '{nrx:4, rx:'{8'h52, 8'h12, 8'h35, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00},
                ntx:1, tx:'{8'hBB, 8'h00}, nwr:0, nchk:1,
                ca:'{16'h1235, 16'h0000, 16'h0000}, cv:'{8'hBB, 8'h00, 8'h00}, busy:1'b1};
      vt[4] = '{nrx:6, rx:'{8'h57, 8'hFF, 8'hFF, 8'h02, 8'hDE, 8'hAD, 8'h00, 8'h00},
                ntx:1, tx:'{8'h2E, 8'h00}, nwr:2, nchk:2,
                ca:'{16'hFFFF, 16'h0000, 16'h0000}, cv:'{8'hDE, 8'hAD, 8'hAD}, busy:1'b1};
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 8'(i) ^ 8'(i >> 8);
         ref_mem[i] = mem[i];
      end
      mem[16'hFFFF] = 8'h11; ref_mem[16'hFFFF] = 8'h11;
      mem[16'h0000] = 8'h22; ref_mem[16'h0000] = 8'h22;

      repeat (3) @(negedge clk);
      check_reset_outputs("in_reset");
      reset = 1'b1;
      repeat (40) @(negedge clk);
      check("init_ctrl_count", 64'(ctrl_writes), 64'(1));
      check("init_ctrl_value", 64'(last_ctrl), 64'(8'h15));
      check("status_polling", 64'(status_reads > 0), 64'(1));

      for (int v = 0; v < 5; v++) begin
         b = {};
         for (int k = 0; k < vt[v].nrx; k++) b.push_back(vt[v].rx[k]);
         model(b, etx, nwr);
         run(b, vt[v].ntx);
         check($sformatf("vec%0d_tx_count", v), 64'(txq.size()), 64'(vt[v].ntx));
         for (int k = 0; k < vt[v].ntx; k++)
            check($sformatf("vec%0d_tx%0d", v, k), 64'((k < txq.size()) ? txq[k] : 8'hxx), 64'(vt[v].tx[k]));
         check($sformatf("vec%0d_writes", v), 64'(wr_count), 64'(vt[v].nwr));
         for (int k = 0; k < vt[v].nchk; k++)
            check($sformatf("vec%0d_mem_%0h", v, vt[v].ca[k]), 64'(mem[vt[v].ca[k]]), 64'(vt[v].cv[k]));
         check($sformatf("vec%0d_busy_seen", v), 64'(busy_seen), 64'(vt[v].busy));
         check($sformatf("vec%0d_busy_end", v), 64'(busy), 64'(0));
      end

      b = {8'h57, 8'h00, 8'h00, 8'h00};
      repeat (256) b.push_back(8'($urandom_range(0, 255)));
      run_model("len256", b);
      check("len256_addr_end", 64'(addr), 64'(16'h0100));

      b = {8'h57, 8'h40, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
      wr_count = 0;
      foreach (b[i]) rxq.push_back(b[i]);
      t = 0;
      while (wr_count < 2 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      check("midreset_reached", 64'(t < 2000), 64'(1));
      @(negedge clk);
      cw0   = ctrl_writes;
      reset = 1'b0;
      #1;
      check_reset_outputs("midreset_assert");
      rxq.delete();
      repeat (5) @(negedge clk);
      check_reset_outputs("midreset_hold");
      reset = 1'b1;
      repeat (40) @(negedge clk);
      check("midreset_writes", 64'(wr_count), 64'(2));
      check("midreset_reinit", 64'(ctrl_writes), 64'(cw0 + 1));
      check("midreset_ctrl_value", 64'(last_ctrl), 64'(8'h15));
      check("midreset_busy", 64'(busy), 64'(0));
      ref_mem[16'h4000] = 8'h11;
      ref_mem[16'h4001] = 8'h22;

      for (int f = 0; f < 8; f++) begin
         b  = {};
         op = ($urandom_range(0, 4) < 2) ? 8'h57 : 8'h52;
         if ($urandom_range(0, 4) == 0) begin
            op = 8'($urandom_range(0, 255));
            if (op == 8'h57 || op == 8'h52) op = 8'h00;
         end
         a = 16'($urandom);
         if ($urandom_range(0, 1) == 1) a = 16'hFFFD + 16'($urandom_range(0, 2));
         b.push_back(op);
         if (op == 8'h57 || op == 8'h52) begin
            b.push_back(a[15:8]);
            b.push_back(a[7:0]);
            b.push_back(8'($urandom_range(1, 5)));
            if (op == 8'h57) for (int k = 0; k < int'(b[3]); k++) b.push_back(8'($urandom_range(0, 255)));
         end
         run_model($sformatf("rand%0d", f), b);
      end

      check("bus_rule_violations", 64'(viol), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/uart_sram_loader.md
UART_SRAM_LOADER -- requirements
Module: uart_sram_loader

Interface
REQ-001 SHALL have parameter INIT_CTRL, default 8'h15, the ACIA control byte written once after reset.
REQ-002 SHALL have parameter ACK_BYTE, default 8'h2E, the byte sent on write-command completion.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port acia_cs, output, 1, ACIA chip select, active high, one-cycle strobe per access.
REQ-006 SHALL have port acia_we, output, 1, ACIA write enable (1 = write, 0 = read), valid with acia_cs.
REQ-007 SHALL have port acia_rs, output, 1, ACIA register select (0 = status/control, 1 = data).
REQ-008 SHALL have port acia_din, output, 8, data written to the ACIA.
REQ-009 SHALL have port acia_dout, input, 8, ACIA read data, valid the cycle after a read strobe.
REQ-010 SHALL have port sram_oe, output, 1, SRAM read enable, active high.
REQ-011 SHALL have port sram_we, output, 1, SRAM write strobe, active high, one cycle per byte.
REQ-012 SHALL have port addr, output, 16, SRAM address.
REQ-013 SHALL have port sram_dout, output, 8, SRAM write data.
REQ-014 SHALL have port sram_din, input, 8, SRAM read data, valid two cycles after sram_oe rises.
REQ-015 SHALL have port busy, output, 1, high while a command is between its first byte and completion.

Function
REQ-016 SHALL poll ACIA status: read strobe with rs=0; status bit0 = RX full (RDRF), bit1 = TX empty (TDRE).
REQ-017 SHALL read RX bytes only after RDRF=1 (strobe rs=1, we=0) and write TX bytes only after TDRE=1 (strobe rs=1, we=1).
REQ-018 SHALL implement states INIT, POLL_RX, GET_RX, CMD, ADDR_HI, ADDR_LO, LEN, WR_MEM, RD_MEM, POLL_TX, PUT_TX.
REQ-019 INIT SHALL issue exactly one control write of INIT_CTRL (rs=0, we=1), then go to POLL_RX.
REQ-020 Command frame: opcode, addr_hi, addr_lo, len; opcode 8'h57 ('W') = write, 8'h52 ('R') = read; any other opcode is discarded with busy left low.
REQ-021 len 8'h00 SHALL mean 256 bytes; byte counter 9 bits wide.
REQ-022 Write: each subsequent RX byte SHALL drive addr, sram_dout and a one-cycle sram_we within 2 cycles of capture; addr then increments.
REQ-023 After the last write byte, SHALL transmit ACK_BYTE once, then clear busy and return to POLL_RX.
REQ-024 Read: per byte, SHALL assert sram_oe, sample sram_din 2 cycles later, then POLL_TX/PUT_TX; addr increments after each byte; no ACK is sent.
REQ-025 addr SHALL wrap 16'hFFFF -> 16'h0000 with no error.
REQ-026 SHALL never assert acia_cs together with sram_we or sram_oe, and never assert sram_we and sram_oe together.
REQ-027 acia_cs SHALL be deasserted for at least one cycle between consecutive ACIA accesses.

Reset
REQ-028 While reset is low: state = INIT; acia_cs, acia_we, acia_rs, sram_oe, sram_we, busy = 0; addr, acia_din, sram_dout = 0; counter cleared.
REQ-029 Reset mid-command SHALL abandon the frame with no further SRAM write, and SHALL rerun INIT after release.

Structure
REQ-030 ACIA register-select values, status bit positions, opcodes and the state encoding SHALL reside in a shared package.
REQ-031 A sub-module acia_bus_master SHALL own the strobe and read-capture timing for single ACIA accesses, with a req/done handshake to the sequencer FSM.

Verification
REQ-032 Release reset -> exactly one acia_cs with we=1, rs=0, acia_din=8'h15, then status polling.
REQ-033 RX 57 12 34 03 AA BB CC -> SRAM 1234=AA, 1235=BB, 1236=CC written, then TX 2E; busy low afterward.
REQ-034 RX 52 FF FF 02 with SRAM FFFF=11, 0000=22 -> TX 11 then 22 (wrap), no ACK.
REQ-035 RX 57 00 00 00 plus 256 bytes -> 256 sram_we pulses, addr ends at 16'h0100, one ACK.
REQ-036 RX 41 -> no SRAM access, no TX, busy stays 0; a following valid frame executes normally.
REQ-037 Reset asserted after the 2nd data byte of a 'W' len 4 frame -> outputs at reset values, no further sram_we, INIT control write repeats.
